// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multicycle MIPS main control, sequencing FETCH/DECODE/EXEC/MEM/WB with memory timeouts.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       memReady,
  input  logic       aluZero,
  input  logic       aluNeg,
  output logic [4:0] aluOp,
  output logic       memRead,
  output logic       memWrite,
  output logic       iorD,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       pcSrc,
  output logic       regWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       illegal,
  output logic       memErr,
  output logic [2:0] state
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
  state_t cur, nxt;
  logic [4:0] cls, cls_nxt, dec;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic legal, is_load, is_store, is_branch, is_r, taken, timeout;
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= FETCH;
      cnt <= '0;
      cls <= '0;
    end else begin
      cur <= nxt;
      cnt <= cnt_nxt;
      cls <= cls_nxt;
    end
  end
  always_comb begin
    dec = 5'd0;
    legal = 1'b1;
    case (opcode)
      6'b000000: dec = 5'b00000;
      6'b011100: begin
        dec = 5'b00001;
        legal = (funct == 6'b100000) || (funct == 6'b100001);
      end
      6'b001000, 6'b001001: dec = 5'b00010;
      6'b001010, 6'b001011: dec = 5'b00011;
      6'b001100: dec = 5'b00100;
      6'b001101: dec = 5'b00101;
      6'b001110: dec = 5'b00110;
      6'b100011, 6'b100001: dec = 5'b01000;
      6'b100101: dec = 5'b01001;
      6'b100000: dec = 5'b01010;
      6'b100100: dec = 5'b01011;
      6'b111111: dec = 5'b01100;
      6'b101011: dec = 5'b01101;
      6'b101001: dec = 5'b01110;
      6'b101000: dec = 5'b01111;
      6'b000100: begin
        dec = 5'b10000;
        legal = (rs == 5'd0) && (rt == 5'd0);
      end
      6'b000111: dec = 5'b10101;
      6'b000110: dec = 5'b10110;
      6'b000001: begin
        dec = 5'b10111;
        legal = (rt == 5'd0);
      end
      default: legal = 1'b0;
    endcase
  end
  // Instruction kind follows from the class-code ranges.
  assign is_r      = cls[4:1] == 4'b0000;
  assign is_load   = cls[4:2] == 3'b010;
  assign is_store  = cls[4:2] == 3'b011;
  assign is_branch = cls[4];
  assign taken     = (cls == 5'b10000) ? 1'b1 :
                     (cls == 5'b10101) ? (!aluNeg && !aluZero) :
                     (cls == 5'b10110) ? (aluNeg || aluZero) :
                     (cls == 5'b10111) ? aluNeg : 1'b0;
  assign timeout   = cnt == CNT_W'(MEM_TIMEOUT - 1);
  assign state     = reset ? 3'd0 : 3'(cur);
  always_comb begin
    nxt = cur;
    cnt_nxt = cnt;
    cls_nxt = cls;
    aluOp = 5'd0;
    memRead = 1'b0;
    memWrite = 1'b0;
    iorD = 1'b0;
    irWrite = 1'b0;
    pcWrite = 1'b0;
    pcSrc = 1'b0;
    regWrite = 1'b0;
    regDst = 1'b0;
    memToReg = 1'b0;
    illegal = 1'b0;
    memErr = 1'b0;
    if (!reset) begin
      case (cur)
        FETCH: begin
          memRead = 1'b1;
          if (memReady) begin
            irWrite = 1'b1;
            pcWrite = 1'b1;
            nxt = DECODE;
            cnt_nxt = '0;
          end else if (timeout) begin
            memErr = 1'b1;
            cnt_nxt = '0;
          end else cnt_nxt = cnt + 1'b1;
        end
        DECODE: begin
          illegal = !legal;
          cls_nxt = legal ? dec : cls;
          nxt = legal ? EXEC : FETCH;
        end
        EXEC: begin
          aluOp = cls;
          pcSrc = is_branch;
          pcWrite = is_branch && taken;
          nxt = is_branch ? FETCH : (is_load || is_store) ? MEM : WB;
        end
        MEM: begin
          iorD = 1'b1;
          memRead = is_load;
          memWrite = is_store;
          if (memReady) begin
            nxt = is_load ? WB : FETCH;
            cnt_nxt = '0;
          end else if (timeout) begin
            memErr = 1'b1;
            nxt = FETCH;
            cnt_nxt = '0;
          end else cnt_nxt = cnt + 1'b1;
        end
        WB: begin
          regWrite = 1'b1;
          regDst = is_r;
          memToReg = is_load;
          nxt = FETCH;
        end
        default: nxt = FETCH;
      endcase
      cnt_nxt = (nxt != cur) ? '0 : cnt_nxt;
    end
  end
endmodule
